// File: rtl/eth_lane_pkg.sv
// Shared definitions for the eth_lane_switch slice: FSM state codes, lane limit and a
// lane-rotation helper.
package eth_lane_pkg;

  localparam int unsigned MAX_LANES = 8;

  localparam logic       RIdle = 1'b0;
  localparam logic       RLock = 1'b1;

  localparam logic [1:0] TIdle = 2'd0;
  localparam logic [1:0] TFwd  = 2'd1;
  localparam logic [1:0] TDrop = 2'd2;

  // Lane reached by stepping 'step' positions after 'base' on a ring of 'lanes' lanes.
  function automatic int unsigned lane_after(input int unsigned base, input int unsigned step,
                                             input int unsigned lanes);
    return (base + step) % lanes;
  endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Round-robin request/grant picker with a rotating priority pointer; the pointer moves to
// the granted lane only when the caller commits the grant.
module eth_rr_arbiter
  import eth_lane_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned LW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LANES-1:0] req_i,
  input  logic             advance_i,
  output logic             gnt_valid_o,
  output logic [LW-1:0]    gnt_idx_o
);

  logic [LW-1:0] ptr_q;

  // Scan from farthest to nearest so the lane just after the pointer wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = ptr_q;
    for (int unsigned k = LANES; k >= 1; k--) begin
      if (req_i[lane_after(int'(ptr_q), k, LANES)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = LW'(lane_after(int'(ptr_q), k, LANES));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= LW'(LANES - 1);
    end else if (advance_i && gnt_valid_o) begin
      ptr_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/eth_lane_switch.sv
// N-lane AXI-Stream switch: packet round-robin RX aggregation tagged with source lane, and
// tdest-steered TX fan-out. Optional counters enabled by ETH_LANE_SWITCH_STATS_EN.
module eth_lane_switch
  import eth_lane_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 64,
  parameter int unsigned LW    = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [LANES-1:0]      lane_up,
  input  logic [LANES*DW-1:0]   s_rx_tdata,
  input  logic [LANES*DW/8-1:0] s_rx_tkeep,
  input  logic [LANES-1:0]      s_rx_tlast,
  input  logic [LANES-1:0]      s_rx_tuser,
  input  logic [LANES-1:0]      s_rx_tvalid,
  output logic [LANES-1:0]      s_rx_tready,
  output logic [DW-1:0]         m_rx_tdata,
  output logic [DW/8-1:0]       m_rx_tkeep,
  output logic                  m_rx_tlast,
  output logic                  m_rx_tuser,
  output logic                  m_rx_tvalid,
  output logic [LW-1:0]         m_rx_tdest,
  input  logic                  m_rx_tready,
  input  logic [DW-1:0]         s_tx_tdata,
  input  logic [DW/8-1:0]       s_tx_tkeep,
  input  logic                  s_tx_tlast,
  input  logic                  s_tx_tuser,
  input  logic                  s_tx_tvalid,
  input  logic [LW-1:0]         s_tx_tdest,
  output logic                  s_tx_tready,
  output logic [LANES*DW-1:0]   m_tx_tdata,
  output logic [LANES*DW/8-1:0] m_tx_tkeep,
  output logic [LANES-1:0]      m_tx_tlast,
  output logic [LANES-1:0]      m_tx_tuser,
  output logic [LANES-1:0]      m_tx_tvalid,
`ifdef ETH_LANE_SWITCH_STATS_EN
  output logic [LANES*32-1:0]   rx_pkt_cnt,
  output logic [LANES*32-1:0]   tx_pkt_cnt,
  output logic [31:0]           tx_drop_cnt,
`endif
  input  logic [LANES-1:0]      m_tx_tready
);

  localparam int unsigned KW = DW / 8;

  if (LANES < 1 || LANES > MAX_LANES || (1 << LW) < LANES) begin : g_param_check
    $error("eth_lane_switch: unsupported LANES/LW combination");
  end

  // ---------------- RX aggregation ----------------
  logic          rx_state_q, rx_state_d;
  logic [LW-1:0] rx_gnt_q, rx_gnt_d;
  logic          arb_valid, arb_adv;
  logic [LW-1:0] arb_idx;
  logic [LANES-1:0] rx_req;
  logic          sel_tvalid;
  logic          rx_done;

  assign rx_req = s_rx_tvalid & lane_up;

  eth_rr_arbiter #(
    .LANES (LANES),
    .LW    (LW)
  ) u_arb (
    .clk_i       (clock),
    .rst_ni      (resetn),
    .req_i       (rx_req),
    .advance_i   (arb_adv),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  always_comb begin
    m_rx_tdata  = '0;
    m_rx_tkeep  = '0;
    m_rx_tlast  = 1'b0;
    m_rx_tuser  = 1'b0;
    sel_tvalid  = 1'b0;
    s_rx_tready = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rx_gnt_q == LW'(i)) begin
        m_rx_tdata     = s_rx_tdata[i*DW +: DW];
        m_rx_tkeep     = s_rx_tkeep[i*KW +: KW];
        m_rx_tlast     = s_rx_tlast[i];
        m_rx_tuser     = s_rx_tuser[i];
        sel_tvalid     = s_rx_tvalid[i];
        s_rx_tready[i] = (rx_state_q == RLock) && m_rx_tready;
      end
    end
    m_rx_tvalid = (rx_state_q == RLock) && sel_tvalid;
  end

  assign m_rx_tdest = rx_gnt_q;
  assign rx_done    = m_rx_tvalid && m_rx_tready && m_rx_tlast;

  // Grant stays locked until tlast even if the lane's link drops.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_gnt_d   = rx_gnt_q;
    arb_adv    = 1'b0;
    if (rx_state_q == RIdle) begin
      if (arb_valid) begin
        rx_gnt_d   = arb_idx;
        rx_state_d = RLock;
        arb_adv    = 1'b1;
      end
    end else if (rx_done) begin
      rx_state_d = RIdle;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rx_state_q <= RIdle;
      rx_gnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_gnt_q   <= rx_gnt_d;
    end
  end

  // ---------------- TX steering ----------------
  logic [1:0]    tx_state_q, tx_state_d;
  logic [LW-1:0] tx_dest_q, tx_dest_d;
  logic          dest_ok;
  logic          sel_tready;
  logic          tx_last_acc;

  always_comb begin
    dest_ok    = 1'b0;
    sel_tready = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s_tx_tdest == LW'(i)) dest_ok = lane_up[i];
      if (tx_dest_q == LW'(i))  sel_tready = m_tx_tready[i];
    end
  end

  always_comb begin
    m_tx_tdata  = {LANES{s_tx_tdata}};
    m_tx_tkeep  = {LANES{s_tx_tkeep}};
    m_tx_tlast  = {LANES{s_tx_tlast}};
    m_tx_tuser  = {LANES{s_tx_tuser}};
    m_tx_tvalid = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      m_tx_tvalid[i] = (tx_state_q == TFwd) && (tx_dest_q == LW'(i)) && s_tx_tvalid;
    end
    unique case (tx_state_q)
      TFwd:    s_tx_tready = sel_tready;
      TDrop:   s_tx_tready = 1'b1;
      default: s_tx_tready = 1'b0;
    endcase
  end

  assign tx_last_acc = s_tx_tvalid && s_tx_tready && s_tx_tlast;

  // Idle only decides the route; the first beat is consumed in Fwd/Drop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_dest_d  = tx_dest_q;
    unique case (tx_state_q)
      TIdle: begin
        if (s_tx_tvalid) begin
          tx_dest_d  = s_tx_tdest;
          tx_state_d = dest_ok ? TFwd : TDrop;
        end
      end
      TFwd, TDrop: begin
        if (tx_last_acc) tx_state_d = TIdle;
      end
      default: tx_state_d = TIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tx_state_q <= TIdle;
      tx_dest_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_dest_q  <= tx_dest_d;
    end
  end

`ifdef ETH_LANE_SWITCH_STATS_EN
  logic [LANES*32-1:0] rx_pkt_cnt_q, tx_pkt_cnt_q;
  logic [31:0]         tx_drop_cnt_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rx_pkt_cnt_q  <= '0;
      tx_pkt_cnt_q  <= '0;
      tx_drop_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (rx_done && rx_gnt_q == LW'(i)) begin
          rx_pkt_cnt_q[i*32 +: 32] <= rx_pkt_cnt_q[i*32 +: 32] + 32'd1;
        end
        if (tx_last_acc && tx_state_q == TFwd && tx_dest_q == LW'(i)) begin
          tx_pkt_cnt_q[i*32 +: 32] <= tx_pkt_cnt_q[i*32 +: 32] + 32'd1;
        end
      end
      if (tx_last_acc && tx_state_q == TDrop) tx_drop_cnt_q <= tx_drop_cnt_q + 32'd1;
    end
  end

  assign rx_pkt_cnt  = rx_pkt_cnt_q;
  assign tx_pkt_cnt  = tx_pkt_cnt_q;
  assign tx_drop_cnt = tx_drop_cnt_q;
`endif

endmodule

// File: tb/tb_eth_lane_switch.sv
// Self-checking bench for eth_lane_switch: queued source packets, per-lane scoreboards and a
// packet-level round-robin order model.
module tb_eth_lane_switch;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned LW    = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic [LW-1:0] dest;
    logic          drop;
  } beat_t;

  logic                  clock = 1'b0;
  logic                  resetn;
  logic [LANES-1:0]      lane_up;
  logic [LANES*DW-1:0]   s_rx_tdata;
  logic [LANES*KW-1:0]   s_rx_tkeep;
  logic [LANES-1:0]      s_rx_tlast, s_rx_tuser, s_rx_tvalid, s_rx_tready;
  logic [DW-1:0]         m_rx_tdata;
  logic [KW-1:0]         m_rx_tkeep;
  logic                  m_rx_tlast, m_rx_tuser, m_rx_tvalid, m_rx_tready;
  logic [LW-1:0]         m_rx_tdest;
  logic [DW-1:0]         s_tx_tdata;
  logic [KW-1:0]         s_tx_tkeep;
  logic                  s_tx_tlast, s_tx_tuser, s_tx_tvalid, s_tx_tready;
  logic [LW-1:0]         s_tx_tdest;
  logic [LANES*DW-1:0]   m_tx_tdata;
  logic [LANES*KW-1:0]   m_tx_tkeep;
  logic [LANES-1:0]      m_tx_tlast, m_tx_tuser, m_tx_tvalid, m_tx_tready;
`ifdef ETH_LANE_SWITCH_STATS_EN
  logic [LANES*32-1:0]   rx_pkt_cnt, tx_pkt_cnt;
  logic [31:0]           tx_drop_cnt;
`endif

  always #5 clock = ~clock;

  eth_lane_switch #(
    .LANES (LANES),
    .DW    (DW),
    .LW    (LW)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .lane_up     (lane_up),
    .s_rx_tdata  (s_rx_tdata),
    .s_rx_tkeep  (s_rx_tkeep),
    .s_rx_tlast  (s_rx_tlast),
    .s_rx_tuser  (s_rx_tuser),
    .s_rx_tvalid (s_rx_tvalid),
    .s_rx_tready (s_rx_tready),
    .m_rx_tdata  (m_rx_tdata),
    .m_rx_tkeep  (m_rx_tkeep),
    .m_rx_tlast  (m_rx_tlast),
    .m_rx_tuser  (m_rx_tuser),
    .m_rx_tvalid (m_rx_tvalid),
    .m_rx_tdest  (m_rx_tdest),
    .m_rx_tready (m_rx_tready),
    .s_tx_tdata  (s_tx_tdata),
    .s_tx_tkeep  (s_tx_tkeep),
    .s_tx_tlast  (s_tx_tlast),
    .s_tx_tuser  (s_tx_tuser),
    .s_tx_tvalid (s_tx_tvalid),
    .s_tx_tdest  (s_tx_tdest),
    .s_tx_tready (s_tx_tready),
    .m_tx_tdata  (m_tx_tdata),
    .m_tx_tkeep  (m_tx_tkeep),
    .m_tx_tlast  (m_tx_tlast),
    .m_tx_tuser  (m_tx_tuser),
    .m_tx_tvalid (m_tx_tvalid),
`ifdef ETH_LANE_SWITCH_STATS_EN
    .rx_pkt_cnt  (rx_pkt_cnt),
    .tx_pkt_cnt  (tx_pkt_cnt),
    .tx_drop_cnt (tx_drop_cnt),
`endif
    .m_tx_tready (m_tx_tready)
  );

  beat_t rx_src [LANES][$];
  beat_t rx_exp [LANES][$];
  beat_t tx_src [$];
  beat_t tx_exp [LANES][$];
  int    rx_order_exp [$];
  int    pkt_cnt [LANES];

  int checks = 0;
  int errors = 0;
  int rx_beats, tx_fwd_beats, tx_src_beats, tx_drops_seen, tx_drop_exp, mtx_valid_cycles;
  int rx_cur_lane;
  bit rx_in_pkt, rx_rand, tx_rand, reached;
  logic [LANES-1:0] tx_ready_fix;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic last, input logic [LW-1:0] dest,
                                    input logic drop);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = last ? KW'($urandom_range(1, 255)) : '1;
    b.last = last;
    b.user = 1'($urandom_range(0, 1));
    b.dest = dest;
    b.drop = drop;
    return b;
  endfunction

  task automatic push_rx(input int lane, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = mk_beat(k == len - 1, LW'(lane), 1'b0);
      rx_src[lane].push_back(b);
      rx_exp[lane].push_back(b);
    end
  endtask

  task automatic push_tx(input int dest, input int len);
    beat_t b;
    logic  drop;
    drop = 1'b1;
    if (dest < LANES) begin
      if (lane_up[dest]) drop = 1'b0;
    end
    if (drop) tx_drop_exp++;
    for (int k = 0; k < len; k++) begin
      b = mk_beat(k == len - 1, LW'(dest), drop);
      tx_src.push_back(b);
      if (!drop) tx_exp[dest].push_back(b);
    end
  endtask

  // Packet-level round robin over pkt_cnt: next packet comes from the first lane after the
  // previous winner that still has packets; lane 0 wins first after reset.
  task automatic build_order();
    int  last_lane;
    int  left;
    bit  found;
    last_lane = LANES - 1;
    left = 0;
    for (int i = 0; i < LANES; i++) left += pkt_cnt[i];
    while (left > 0) begin
      found = 1'b0;
      for (int s = 1; s <= LANES; s++) begin
        if (!found && pkt_cnt[(last_lane + s) % LANES] > 0) begin
          found = 1'b1;
          last_lane = (last_lane + s) % LANES;
        end
      end
      rx_order_exp.push_back(last_lane);
      pkt_cnt[last_lane]--;
      left--;
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < LANES; i++) begin
      if (rx_src[i].size() > 0) begin
        b = rx_src[i][0];
        s_rx_tvalid[i] = 1'b1;
        s_rx_tdata[i*DW +: DW] = b.data;
        s_rx_tkeep[i*KW +: KW] = b.keep;
        s_rx_tlast[i] = b.last;
        s_rx_tuser[i] = b.user;
      end else begin
        s_rx_tvalid[i] = 1'b0;
        s_rx_tdata[i*DW +: DW] = '0;
        s_rx_tkeep[i*KW +: KW] = '0;
        s_rx_tlast[i] = 1'b0;
        s_rx_tuser[i] = 1'b0;
      end
      m_tx_tready[i] = tx_rand ? 1'($urandom_range(0, 1)) : tx_ready_fix[i];
    end
    m_rx_tready = rx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (tx_src.size() > 0) begin
      b = tx_src[0];
      s_tx_tvalid = 1'b1;
      s_tx_tdata  = b.data;
      s_tx_tkeep  = b.keep;
      s_tx_tlast  = b.last;
      s_tx_tuser  = b.user;
      s_tx_tdest  = b.dest;
    end else begin
      s_tx_tvalid = 1'b0;
      s_tx_tdata  = '0;
      s_tx_tkeep  = '0;
      s_tx_tlast  = 1'b0;
      s_tx_tuser  = 1'b0;
      s_tx_tdest  = '0;
    end
  endtask

  task automatic rx_sink();
    beat_t e;
    int    lane;
    lane = int'(m_rx_tdest);
    rx_beats++;
    if (!rx_in_pkt) begin
      if (rx_order_exp.size() > 0) check("rx_grant_order", lane, rx_order_exp.pop_front());
    end else begin
      check("rx_no_interleave", lane, rx_cur_lane);
    end
    rx_in_pkt   = !m_rx_tlast;
    rx_cur_lane = lane;
    if (lane < LANES && rx_exp[lane].size() > 0) begin
      e = rx_exp[lane].pop_front();
      check("rx_beat", {m_rx_tdata, m_rx_tkeep, m_rx_tlast, m_rx_tuser},
            {e.data, e.keep, e.last, e.user});
    end else begin
      check("rx_unexpected_beat_lane", lane, '1);
    end
  endtask

  task automatic tx_sink(input int lane);
    beat_t e;
    tx_fwd_beats++;
    if (tx_exp[lane].size() > 0) begin
      e = tx_exp[lane].pop_front();
      check("tx_beat", {m_tx_tdata[lane*DW +: DW], m_tx_tkeep[lane*KW +: KW],
                        m_tx_tlast[lane], m_tx_tuser[lane]}, {e.data, e.keep, e.last, e.user});
    end else begin
      check("tx_unexpected_beat_lane", lane, '1);
    end
  endtask

  task automatic cycle();
    logic [LANES-1:0] rx_pop;
    logic             tx_pop;
    @(negedge clock);
    rx_pop = s_rx_tvalid & s_rx_tready;
    tx_pop = s_tx_tvalid & s_tx_tready;
    if (|m_tx_tvalid) mtx_valid_cycles++;
    if (m_rx_tvalid && m_rx_tready) rx_sink();
    for (int i = 0; i < LANES; i++) begin
      if (m_tx_tvalid[i] && m_tx_tready[i]) tx_sink(i);
    end
    if (tx_pop) begin
      tx_src_beats++;
      if (tx_src[0].drop && tx_src[0].last) tx_drops_seen++;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < LANES; i++) begin
      if (rx_pop[i] && rx_src[i].size() > 0) void'(rx_src[i].pop_front());
    end
    if (tx_pop && tx_src.size() > 0) void'(tx_src.pop_front());
    drive();
  endtask

  function automatic int pending();
    int n;
    n = tx_src.size();
    for (int i = 0; i < LANES; i++) n += rx_exp[i].size() + tx_exp[i].size();
    return n;
  endfunction

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, pending(), 0);
  endtask

  // Reset applied with current inputs held; outputs checked right after the reset edge.
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check({tag, "_m_rx_tvalid"}, m_rx_tvalid, 1'b0);
    check({tag, "_s_rx_tready"}, s_rx_tready, '0);
    check({tag, "_m_rx_tdest"}, m_rx_tdest, '0);
    check({tag, "_s_tx_tready"}, s_tx_tready, 1'b0);
    check({tag, "_m_tx_tvalid"}, m_tx_tvalid, '0);
    for (int i = 0; i < LANES; i++) begin
      rx_src[i].delete();
      rx_exp[i].delete();
      tx_exp[i].delete();
    end
    tx_src.delete();
    rx_order_exp.delete();
    rx_in_pkt = 1'b0;
    rx_beats = 0; tx_fwd_beats = 0; tx_src_beats = 0;
    tx_drops_seen = 0; tx_drop_exp = 0; mtx_valid_cycles = 0;
    drive();
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn       = 1'b0;
    lane_up      = '1;
    rx_rand      = 1'b0;
    tx_rand      = 1'b0;
    tx_ready_fix = '1;
    s_rx_tvalid  = '0;
    s_rx_tdata   = '0;
    s_rx_tkeep   = '0;
    s_rx_tlast   = '0;
    s_rx_tuser   = '0;
    drive();
    @(posedge clock);
    #1;
    do_reset("reset");

    // Lanes 0 and 2 start together: lane 0 first, then lane 2, never interleaved.
    push_rx(0, 3);
    push_rx(2, 3);
    pkt_cnt = '{1, 0, 1, 0};
    build_order();
    drive();
    run_until_drained("t1", 50);
    check("t1_order_consumed", rx_order_exp.size(), 0);

    // All lanes continuously valid: strict 0,1,2,3 rotation.
    do_reset("t2_reset");
    for (int p = 0; p < 3; p++) begin
      for (int l = 0; l < LANES; l++) push_rx(l, $urandom_range(1, 4));
    end
    pkt_cnt = '{3, 3, 3, 3};
    build_order();
    drive();
    run_until_drained("t2", 200);
    check("t2_order_consumed", rx_order_exp.size(), 0);

    // Random backpressure over 1000 packets from random lanes.
    do_reset("t3_reset");
    pkt_cnt = '{0, 0, 0, 0};
    for (int p = 0; p < 1000; p++) begin
      int l;
      l = $urandom_range(0, LANES - 1);
      push_rx(l, $urandom_range(1, 4));
      pkt_cnt[l]++;
    end
    build_order();
    rx_rand = 1'b1;
    drive();
    run_until_drained("t3", 30000);
    check("t3_order_consumed", rx_order_exp.size(), 0);
    rx_rand = 1'b0;

    // Out-of-range tdest is dropped even with every MAC stalled.
    do_reset("t4_reset");
    tx_ready_fix = '0;
    push_tx(5, 4);
    drive();
    run_cycles(6);
    check("t4_drop_beats_taken", tx_src_beats, 4);
    check("t4_no_m_tx_tvalid", mtx_valid_cycles, 0);
    check("t4_drop_count", tx_drops_seen, 1);
`ifdef ETH_LANE_SWITCH_STATS_EN
    check("t4_tx_drop_cnt", tx_drop_cnt, 32'd1);
`endif
    tx_ready_fix = '1;

    // Lane 1 link drops mid-packet: packet finishes, no new grant until the link returns.
    do_reset("t5_reset");
    push_rx(1, 4);
    drive();
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      cycle();
      if (rx_beats >= 2) reached = 1'b1;
    end
    check("t5_two_beats_seen", reached, 1'b1);
    lane_up[1] = 1'b0;
    run_until_drained("t5_complete", 50);
    check("t5_beats_total", rx_beats, 4);
    push_rx(1, 2);
    drive();
    run_cycles(20);
    check("t5_held_off", rx_beats, 4);
    lane_up[1] = 1'b1;
    run_until_drained("t5_regrant", 50);
    check("t5_beats_after", rx_beats, 6);

    // Random TX routing with lane 3 down and random MAC backpressure.
    do_reset("t7_reset");
    lane_up = 4'b0111;
    tx_rand = 1'b1;
    for (int p = 0; p < 40; p++) push_tx($urandom_range(0, 5), $urandom_range(1, 4));
    drive();
    run_until_drained("t7", 2000);
    check("t7_drops", tx_drops_seen, tx_drop_exp);
    tx_rand = 1'b0;
    lane_up = '1;

    // Reset in the middle of a forwarded TX packet, then a clean packet pair.
    do_reset("t6_pre");
    push_tx(2, 6);
    drive();
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      cycle();
      if (tx_fwd_beats >= 2) reached = 1'b1;
    end
    check("t6_mid_packet", reached, 1'b1);
    do_reset("t6_midpkt");
    push_tx(1, 3);
    push_tx(3, 1);
    drive();
    run_until_drained("t6_after", 50);
    check("t6_fwd_beats", tx_fwd_beats, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
